// File: rtl/xgmii_pkg.sv
// Shared XGMII constants, character codes and arbiter state encoding.
package xgmii_pkg;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;

    localparam logic [71:0] XGMII_IDLE_WORD     = {8'hff, {8{XGMII_IDLE}}};
    localparam logic [71:0] XGMII_ERR_TERM_WORD = {8'hff, {7{XGMII_IDLE}}, XGMII_TERM};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FRAME = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    // Width of a counter that must hold values up to the largest of three limits.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/xgmii_term_detect.sv
// Classifies one {txc,txd} XGMII word: start character in lane 0, terminate in any lane.
module xgmii_term_detect
    import xgmii_pkg::*;
(
    input  logic [71:0] word,
    output logic        is_start,
    output logic        has_term
);

    always_comb begin
        is_start = word[64] && (word[7:0] == XGMII_START);
        has_term = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (word[64 + k] && (word[8*k +: 8] == XGMII_TERM)) begin
                has_term = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_tx_arbiter.sv
// Two-source XGMII transmit arbiter: round-robin at frame boundaries, enforced
// inter-frame gap, start timeout and oversize-frame abort.
module xgmii_tx_arbiter
    import xgmii_pkg::*;
#(
    parameter int unsigned IFG_CYCLES      = 1,
    parameter int unsigned START_TIMEOUT   = 16,
    parameter int unsigned MAX_FRAME_WORDS = 1024
) (
    input  logic        xgmii_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [71:0] src0_txd,
    input  logic [71:0] src1_txd,
    output logic [71:0] xgmii_txd,
    output logic        busy,
    output logic [15:0] abort_cnt
);

    localparam int unsigned CNT_W = cnt_width(IFG_CYCLES, START_TIMEOUT, MAX_FRAME_WORDS);
    localparam arb_state_e  END_STATE = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [71:0]       txd_q, txd_d;
    logic [15:0]       abort_q, abort_d;
    logic              busy_q, busy_d;

    logic [71:0]       src_word_c;
    logic              src_req_c;
    logic              is_start_c;
    logic              has_term_c;
    logic [15:0]       abort_inc_c;
    logic              sel_c;

    // Only the granted source is ever looked at.
    assign src_word_c  = gnt_q[1] ? src1_txd : src0_txd;
    assign src_req_c   = gnt_q[1] ? req[1]   : req[0];
    assign abort_inc_c = (abort_q == 16'hffff) ? abort_q : abort_q + 16'd1;

    xgmii_term_detect u_term_detect (
        .word     (src_word_c),
        .is_start (is_start_c),
        .has_term (has_term_c)
    );

    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
            txd_q     <= XGMII_IDLE_WORD;
            abort_q   <= 16'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            txd_q     <= txd_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        txd_d     = XGMII_IDLE_WORD;
        abort_d   = abort_q;
        sel_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    sel_c     = (req == 2'b11) ? ~rr_last_q : req[1];
                    gnt_d     = sel_c ? 2'b10 : 2'b01;
                    rr_last_d = sel_c;
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (is_start_c) begin
                    txd_d   = src_word_c;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_FRAME;
                end else if (!src_req_c) begin
                    gnt_d   = 2'b00;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    gnt_d   = 2'b00;
                    abort_d = abort_inc_c;
                    cnt_d   = '0;
                    state_d = END_STATE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FRAME: begin
                // A word carrying both start and terminate is malformed and treated as data.
                if (has_term_c && !is_start_c) begin
                    txd_d   = src_word_c;
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                    state_d = END_STATE;
                end else if (cnt_q == CNT_W'(MAX_FRAME_WORDS - 1)) begin
                    txd_d   = XGMII_ERR_TERM_WORD;
                    gnt_d   = 2'b00;
                    abort_d = abort_inc_c;
                    cnt_d   = '0;
                    state_d = END_STATE;
                end else begin
                    txd_d = src_word_c;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d   = 2'b00;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign gnt       = gnt_q;
    assign xgmii_txd = txd_q;
    assign busy      = busy_q;
    assign abort_cnt = abort_q;

endmodule

// File: doc/xgmii_tx_arbiter.md
Name: xgmii_tx_arbiter

Overview:
- Shares the single 10G XGMII transmit port between two frame sources, for example the PCIe-to-UDP TX engine and a future ARP/ICMP responder.
- Grants one source at a time and forwards its 72-bit {txc,txd} words. It switches only at frame boundaries, detected by start/terminate control characters.
- Enforces a minimum inter-frame gap and guards against stalled or runaway sources.
- Sits between the TX engines and the 10GBASE-R PCS/PHY.

Parameters:
- IFG_CYCLES, 1: number of all-idle words (8'hff / 64'h0707070707070707) forced after each frame, counted after the word carrying the terminate character.
- START_TIMEOUT, 16: maximum number of cycles after a grant for the start word to appear; at the limit the grant is withdrawn.
- MAX_FRAME_WORDS, 1024: maximum number of words forwarded per frame before a forced abort.

Ports:
- xgmii_clk  in  1  sole clock
- sys_rst_n  in  1  asynchronous, active-low reset
- req  in  2  per-source transmit request; bit i belongs to source i
- gnt  out  2  one-hot-or-zero grant, registered
- src0_txd  in  72  source 0 XGMII word {txc[7:0], txd[63:0]}; lane 0 is the LSB byte
- src1_txd  in  72  source 1 XGMII word, same format
- xgmii_txd  out  72  XGMII word to the PHY, registered
- busy  out  1  high in any state other than IDLE
- abort_cnt  out  16  saturating count of timeouts plus oversize aborts

Behaviour:
- Reset (async assert, sync-style deassert handled by the top level):
  - gnt=0, busy=0, abort_cnt=0
  - xgmii_txd={8'hff, 64'h0707070707070707}
  - state=IDLE, rr_last=1, so source 0 wins first
- Word definitions:
  - Start word: txc[0]=1 and txd[7:0]=8'hFB.
  - Terminate: any lane k with txc[k]=1 and txd[8k+7:8k]=8'hFD.
- Latency: the granted source's word appears on xgmii_txd one cycle after it is sampled.
- When not forwarding, xgmii_txd carries the idle word.
- State IDLE:
  - If any req bit is high, select a source round-robin. When both request, pick the source != rr_last.
  - Set gnt for the selected source, load rr_last, clear the counter, go to WAIT.
- State WAIT:
  - Each cycle, sample the granted source's word.
  - If it is a start word, forward it, reset word_cnt=1 and go to FRAME.
  - Otherwise output idle.
  - If the granted source drops req before its start word: gnt<=0, return to IDLE, no abort counted.
  - At counter==START_TIMEOUT-1 without a start word: gnt<=0, abort_cnt++ (saturating at 16'hffff), go to GAP.
- State FRAME:
  - Forward each word verbatim and increment word_cnt.
  - req is ignored in this state; the frame ends only on terminate or abort.
  - On a word containing terminate: forward it, gnt<=0, go to GAP with gap counter=IFG_CYCLES.
  - If word_cnt reaches MAX_FRAME_WORDS without terminate: output {8'hff, 64'h07070707070707FD} in place of the source word (lane 0 error-terminate), gnt<=0, abort_cnt++, go to GAP.
- State GAP:
  - Output idle for IFG_CYCLES cycles, then go to IDLE.
  - With IFG_CYCLES=0, go straight from terminate to IDLE. A new grant is then possible on the next cycle.
- Corner cases:
  - A start and a terminate in the same word (malformed): treat it as start, stay in FRAME.
  - A second start word inside FRAME is forwarded as data.
  - A reset asserted mid-frame truncates output immediately to idle. The PHY sees a frame without terminate, which is acceptable on reset.
  - gnt changes only in IDLE→WAIT and on exit from WAIT/FRAME. It is never high for both sources.

Decomposition:
- Shared package xgmii_pkg:
  - XGMII_IDLE_WORD and XGMII_ERR_TERM_WORD constants
  - char constants START=8'hFB, TERM=8'hFD, IDLE=8'h07
  - state enum {IDLE, WAIT, FRAME, GAP}
- Sub-module xgmii_term_detect: combinational; a 72-bit word in, outputs is_start and has_term. It is reusable by the RX path and the TX engines.

Test Plan:
- Single source: req=2'b01; src0 sends the start word, 7 data words, then {8'hf0, 32'h070707fd, crc}. Expect gnt=2'b01, the same 9 words on xgmii_txd delayed by 1 cycle, gnt=0 after the terminate word, then 1 idle word and busy=0.
- Contention: req=2'b11 continuously, each source sends 68-byte frames. Expect grants alternating 01,10,01,…, exactly IFG_CYCLES idle words between frames, and no interleaving of words within a frame.
- Start timeout: req=2'b10 with src1 held idle. Expect gnt=2'b10 for 16 cycles, then gnt=0, abort_cnt=1, and source 0 served next if requesting.
- Oversize: MAX_FRAME_WORDS=8, src0 sends the start word then 20 words without a terminate. Expect the 8th output word = {8'hff, 64'h07070707070707FD}, abort_cnt=1, and the remaining source words dropped.
- Reset mid-frame: assert sys_rst_n=0 on word 4 of a frame. Expect xgmii_txd=idle and gnt=0 in the same cycle (asynchronous), and after release the next grant goes to source 0.
- Request withdrawal: src0 drops req during WAIT. Expect gnt=0 next cycle, abort_cnt unchanged, and no idle gap inserted.
